uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a built-in transmit FIFO and a valid/ready write handshake. It replaces the single-word, enable-driven transmitter: the host streams words without waiting for each frame to finish, and back-to-back frames leave the line with no idle gap. Data width, stop-bit count and FIFO depth are parameters; parity is an optional compile-time feature. It sits between the host-side logic and the physical `tx` pin.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_fifo.sv | 49 ++++
 rtl/uart_tx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state type and divider/frame helpers for the FIFO-fed UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

  // Clock cycles per bit, truncated.
  function automatic int uart_div(input int clk_khz, input int bitstream);
    return (clk_khz * 1000) / bitstream;
  endfunction

  function automatic int uart_frame_bits(input int data_amount, input int stop_bits);
`ifdef UART_TX_PARITY_EN
    return 1 + data_amount + 1 + stop_bits;
`else
    return 1 + data_amount + stop_bits;
`endif
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; the level counter alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a valid/ready FIFO; frames run back-to-back while words are queued.
// Optional parity bit is compiled in with UART_TX_PARITY_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_kHZ     = 50000,
  parameter int BITSTREAM   = 9600,
  parameter int DATA_AMOUNT = 8,
  parameter int STOP_BITS   = 1,
  parameter int DEPTH       = 4,
  parameter int PARITY_ODD  = 0
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     valid_i,
  input  logic [DATA_AMOUNT-1:0]   data_i,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     tx_o
);

  localparam int DIV = uart_div(CLK_kHZ, BITSTREAM);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DATA_AMOUNT < 5 || DATA_AMOUNT > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      DIV < 2) begin : g_param_check
    $error("uart_tx_fifo: illegal parameter combination");
  end

  tx_state_e              state;
  tx_state_e              state_next;
  logic [CW-1:0]          baud_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_AMOUNT-1:0] shift;
  logic [DATA_AMOUNT-1:0] fifo_data;
  logic                   bit_end;
  logic                   last_data;
  logic                   last_stop;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                   parity_bit;
`endif

  assign ready_o   = !fifo_full;
  assign push      = valid_i && ready_o;
  assign busy_o    = (state != IDLE);
  assign bit_end   = (baud_cnt == CW'(DIV - 1));
  assign last_data = (bit_cnt == 4'(DATA_AMOUNT - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));

  uart_fifo #(
    .WIDTH (DATA_AMOUNT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (arst_i),
    .push  (push),
    .pop   (pop),
    .wdata (data_i),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  // tx_o is decoded from state so an asynchronous reset forces the line high at once.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_o       = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx_o = shift[0];
`ifdef UART_TX_PARITY_EN
        if (bit_end && last_data) state_next = PARITY;
`else
        if (bit_end && last_data) state_next = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_o = parity_bit;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end && last_stop) begin
          if (!fifo_empty) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit counter restarts on every state change, so it indexes data bits and stop bits alike.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;
      if (state_next != state) bit_cnt <= '0;
      else if (bit_end)        bit_cnt <= bit_cnt + 1'b1;
      if (pop)                          shift <= fifo_data;
      else if (state == DATA && bit_end) shift <= shift >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)   parity_bit <= 1'b0;
    else if (pop) parity_bit <= (^fifo_data) ^ (PARITY_ODD != 0);
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single frames plus back-to-back, full-FIFO,
// mid-frame reset and two-stop-bit sequences. Short bit period keeps the run small.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CLK_KHZ = 1000;
  localparam int BAUD    = 100000;
  localparam int DIV     = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_BITS  = 10 + PBITS;
  localparam int FRAME       = FRAME_BITS * DIV;
  localparam int FRAME2_BITS = 11 + PBITS;
  localparam int FRAME2      = FRAME2_BITS * DIV;

  logic       clk = 1'b0;
  logic       arst;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       busy;
  logic [2:0] level;
  logic       tx;
  logic       valid2;
  logic [7:0] data2;
  logic       ready2;
  logic       busy2;
  logic [1:0] level2;
  logic       tx2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];

  typedef struct {
    logic [7:0] data;
    logic [0:7] seq;
    logic       even_par;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_kHZ(CLK_KHZ), .BITSTREAM(BAUD), .DATA_AMOUNT(8),
    .STOP_BITS(1), .DEPTH(4), .PARITY_ODD(0)
  ) u_dut (
    .clk_i(clk), .arst_i(arst), .valid_i(valid), .data_i(data),
    .ready_o(ready), .busy_o(busy), .level_o(level), .tx_o(tx)
  );

  uart_tx_fifo #(
    .CLK_kHZ(CLK_KHZ), .BITSTREAM(BAUD), .DATA_AMOUNT(8),
    .STOP_BITS(2), .DEPTH(2), .PARITY_ODD(0)
  ) u_dut2 (
    .clk_i(clk), .arst_i(arst), .valid_i(valid2), .data_i(data2),
    .ready_o(ready2), .busy_o(busy2), .level_o(level2), .tx_o(tx2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Push one word into an idle DUT and check the one-cycle write-to-start latency.
  task automatic applyStimulus(input string nm, input logic [7:0] w);
    checkOutput({nm, " ready before push"}, ready, 1'b1);
    valid = 1'b1;
    data  = w;
    tick();
    valid = 1'b0;
    data  = ~w;
    checkOutput({nm, " level after accept"}, level, 3'd1);
    checkOutput({nm, " tx idle after accept"}, tx, 1'b1);
    checkOutput({nm, " busy low after accept"}, busy, 1'b0);
    tick();
    checkOutput({nm, " level after pop"}, level, 3'd0);
  endtask

  // Called at offset 0 of a start bit; checks the first and last cycle of every bit.
  task automatic check_frame(input string nm, input logic [0:7] seq, input logic par);
    logic exp_bits[16];
    int nb;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = seq[i];
    nb = 9;
    if (PBITS == 1) begin
      exp_bits[nb] = par;
      nb++;
    end
    exp_bits[nb] = 1'b1;
    nb++;
    for (int b = 0; b < nb; b++) begin
      checkOutput($sformatf("%s bit%0d first cycle", nm, b), tx, exp_bits[b]);
      repeat (DIV - 1) tick();
      checkOutput($sformatf("%s bit%0d last cycle", nm, b), tx, exp_bits[b]);
      checkOutput($sformatf("%s bit%0d busy", nm, b), busy, 1'b1);
      tick();
    end
  endtask

  // Independent line receiver: samples mid-bit and queues the decoded data byte.
  initial begin : rx_monitor
    logic [7:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (arst === 1'b0 && tx === 1'b0) begin
        repeat (DIV + DIV / 2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          w[i] = tx;
          repeat (DIV) @(posedge clk);
          #1;
        end
        if (PBITS == 1) begin
          repeat (DIV) @(posedge clk);
          #1;
        end
        rx_q.push_back(w);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [7:0] words[6];
    logic       seq2[FRAME2_BITS];
    int waited;
    int active;
    int errs;

    vecs[0] = '{8'h72, 8'b01001110, 1'b0};
    vecs[1] = '{8'hA1, 8'b10000101, 1'b1};
    vecs[2] = '{8'h55, 8'b10101010, 1'b0};
    vecs[3] = '{8'h00, 8'b00000000, 1'b0};
    vecs[4] = '{8'hFF, 8'b11111111, 1'b0};
    vecs[5] = '{8'h80, 8'b00000001, 1'b1};

    arst   = 1'b1;
    valid  = 1'b0;
    data   = 8'h00;
    valid2 = 1'b0;
    data2  = 8'h00;
    repeat (3) tick();
    checkOutput("reset tx", tx, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset level", level, 3'd0);
    checkOutput("reset ready", ready, 1'b1);
    checkOutput("reset level2", level2, 2'd0);
    arst = 1'b0;
    repeat (2) tick();
    checkOutput("post-reset tx", tx, 1'b1);
    checkOutput("post-reset busy", busy, 1'b0);

    // Single frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      applyStimulus($sformatf("vec%0d", v), vecs[v].data);
      check_frame($sformatf("vec%0d", v), vecs[v].seq, vecs[v].even_par);
      checkOutput($sformatf("vec%0d busy falls at frame end", v), busy, 1'b0);
      checkOutput($sformatf("vec%0d tx idle at frame end", v), tx, 1'b1);
      repeat (3) tick();
    end

    // Back-to-back frames with no idle gap.
    rx_q.delete();
    valid = 1'b1;
    data  = 8'h72;
    tick();
    data  = 8'hA1;
    tick();
    valid = 1'b0;
    data  = 8'h00;
    checkOutput("b2b level with second queued", level, 3'd1);
    check_frame("b2b first", vecs[0].seq, vecs[0].even_par);
    check_frame("b2b second", vecs[1].seq, vecs[1].even_par);
    checkOutput("b2b busy falls", busy, 1'b0);
    checkOutput("b2b rx count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      checkOutput("b2b rx word0", rx_q[0], 8'h72);
      checkOutput("b2b rx word1", rx_q[1], 8'hA1);
    end
    repeat (3) tick();

    // Full FIFO: six words with valid held high.
    rx_q.delete();
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hC3};
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = words[i];
      checkOutput($sformatf("full ready before word%0d", i), ready, 1'b1);
      tick();
    end
    data = words[5];
    checkOutput("full level", level, 3'd4);
    checkOutput("full ready low", ready, 1'b0);
    waited = 0;
    while (!ready && waited < 3 * FRAME) begin
      tick();
      waited++;
    end
    checkOutput("full word5 stall cycles", waited, FRAME - 3);
    tick();
    valid = 1'b0;
    data  = 8'h00;
    checkOutput("full level after word5", level, 3'd4);
    waited = 0;
    while (busy && waited < 7 * FRAME) begin
      tick();
      waited++;
    end
    checkOutput("full continuous busy cycles", waited, 5 * FRAME - 1);
    repeat (2) tick();
    checkOutput("full rx count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rx_q.size()) checkOutput($sformatf("full rx word%0d", i), rx_q[i], words[i]);
    end
    repeat (3) tick();

    // Reset during data bit 3 of 0x72 with 0xA1 queued.
    valid = 1'b1;
    data  = 8'h72;
    tick();
    data  = 8'hA1;
    tick();
    valid = 1'b0;
    repeat (4 * DIV + 2) tick();
    checkOutput("rst data bit3 on line", tx, 1'b0);
    checkOutput("rst level before", level, 3'd1);
    arst = 1'b1;
    #1;
    checkOutput("rst async tx", tx, 1'b1);
    checkOutput("rst async busy", busy, 1'b0);
    checkOutput("rst async level", level, 3'd0);
    checkOutput("rst async ready", ready, 1'b1);
    tick();
    arst   = 1'b0;
    active = 0;
    repeat (FRAME + 2 * DIV) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) active++;
    end
    rx_q.delete();
    repeat (2 * FRAME) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) active++;
    end
    checkOutput("rst no frame after release", active, 0);
    checkOutput("rst no rx after release", rx_q.size(), 0);
    checkOutput("rst level stays empty", level, 3'd0);
    applyStimulus("after rst", 8'h55);
    check_frame("after rst", vecs[2].seq, vecs[2].even_par);
    checkOutput("after rst busy falls", busy, 1'b0);

    // Two stop bits on the second instance.
    seq2[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq2[1 + i] = vecs[2].seq[i];
    if (PBITS == 1) seq2[9] = vecs[2].even_par;
    seq2[9 + PBITS]  = 1'b1;
    seq2[10 + PBITS] = 1'b1;
    checkOutput("stop2 ready before push", ready2, 1'b1);
    valid2 = 1'b1;
    data2  = 8'h55;
    tick();
    valid2 = 1'b0;
    tick();
    checkOutput("stop2 start falls", tx2, 1'b0);
    errs = 0;
    for (int c = 0; c < FRAME2; c++) begin
      if (tx2 !== seq2[c / DIV]) errs++;
      if (busy2 !== 1'b1) errs++;
      tick();
    end
    checkOutput("stop2 frame cycle errors", errs, 0);
    checkOutput("stop2 busy falls at frame end", busy2, 1'b0);
    checkOutput("stop2 tx idle at frame end", tx2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
